// File: rtl/arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and requester indices.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      RDATA = 1'b1
   } state_e;

   localparam logic REQ_CORE   = 1'b0;
   localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin picker: one-hot grant from a request pair and the index granted last.
module rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // Contention: favour whoever was not served last.
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a core port and a loader/debug port onto one synchronous memory port,
// allowing at most one outstanding load.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic [2:0]        r0_funct3,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,

   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   input  logic [2:0]        r1_funct3,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_funct3,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e     r_state;
   state_e     w_state_next;
   logic       r_owner;
   logic       w_owner_next;
   logic       r_last;
   logic       w_last_next;
   logic [1:0] w_pick;
   logic [1:0] w_gnt;
   logic       w_sel_r1;
   logic       w_gnt_we;

   rr_pick u_rr_pick (
      .req  ({r1_req, r0_req}),
      .last (r_last),
      .gnt  (w_pick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_owner <= REQ_CORE;
         // Pretend the loader was served last so the core wins the first contention.
         r_last  <= REQ_LOADER;
      end else begin
         r_state <= w_state_next;
         r_owner <= w_owner_next;
         r_last  <= w_last_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_last_next  = r_last;
      w_gnt        = 2'b00;
      w_gnt_we     = 1'b0;
      case (r_state)
         IDLE: begin
            // Grants are combinational, so gate them while reset is held.
            if (rst_n) begin
               w_gnt = w_pick;
            end
            w_gnt_we = (w_gnt[0] & r0_we) | (w_gnt[1] & r1_we);
            if (w_gnt != 2'b00) begin
               w_last_next = w_gnt[1] ? REQ_LOADER : REQ_CORE;
               if (!w_gnt_we) begin
                  w_state_next = RDATA;
                  w_owner_next = w_gnt[1] ? REQ_LOADER : REQ_CORE;
               end
            end
         end
         RDATA: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign w_sel_r1   = w_gnt[1];
   assign mem_addr   = w_sel_r1 ? r1_addr   : r0_addr;
   assign mem_wdata  = w_sel_r1 ? r1_wdata  : r0_wdata;
   assign mem_funct3 = w_sel_r1 ? r1_funct3 : r0_funct3;
   assign mem_wren   = w_gnt_we;

   assign r0_gnt    = w_gnt[0];
   assign r1_gnt    = w_gnt[1];
   assign r0_rvalid = (r_state == RDATA) && (r_owner == REQ_CORE);
   assign r1_rvalid = (r_state == RDATA) && (r_owner == REQ_LOADER);
   assign r0_rdata  = mem_rdata;
   assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter with a simple synchronous memory model.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
   logic [2:0]  r0_funct3, r1_funct3;
   logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
   logic [31:0] r0_rdata, r1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_funct3;
   logic        mem_wren;

   int checks;
   int errors;

   mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .r0_req     (r0_req),
      .r0_we      (r0_we),
      .r0_addr    (r0_addr),
      .r0_wdata   (r0_wdata),
      .r0_funct3  (r0_funct3),
      .r0_gnt     (r0_gnt),
      .r0_rvalid  (r0_rvalid),
      .r0_rdata   (r0_rdata),
      .r1_req     (r1_req),
      .r1_we      (r1_we),
      .r1_addr    (r1_addr),
      .r1_wdata   (r1_wdata),
      .r1_funct3  (r1_funct3),
      .r1_gnt     (r1_gnt),
      .r1_rvalid  (r1_rvalid),
      .r1_rdata   (r1_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_funct3 (mem_funct3),
      .mem_wren   (mem_wren),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory model: registered read of whatever address is presented, 1-cycle latency.
   always @(posedge clk) mem_rdata <= memf(mem_addr);

   typedef struct {
      logic        r0_req, r0_we;
      logic [31:0] r0_addr, r0_wdata;
      logic        r1_req, r1_we;
      logic [31:0] r1_addr, r1_wdata;
      logic        e_g0, e_g1, e_rv0, e_rv1, e_wren;
      logic [31:0] e_addr, e_wdata, e_rdata;
   } vec_t;

   localparam int NV = 18;
   vec_t tv[NV];

   function automatic vec_t mk(
      input logic a_req, input logic a_we, input logic [31:0] a_addr, input logic [31:0] a_wd,
      input logic b_req, input logic b_we, input logic [31:0] b_addr, input logic [31:0] b_wd,
      input logic g0, input logic g1, input logic rv0, input logic rv1, input logic wren,
      input logic [31:0] ea, input logic [31:0] ew, input logic [31:0] er);
      vec_t v;
      v.r0_req = a_req; v.r0_we = a_we; v.r0_addr = a_addr; v.r0_wdata = a_wd;
      v.r1_req = b_req; v.r1_we = b_we; v.r1_addr = b_addr; v.r1_wdata = b_wd;
      v.e_g0 = g0; v.e_g1 = g1; v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_wren = wren;
      v.e_addr = ea; v.e_wdata = ew; v.e_rdata = er;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      r0_req = v.r0_req; r0_we = v.r0_we; r0_addr = v.r0_addr; r0_wdata = v.r0_wdata;
      r1_req = v.r1_req; r1_we = v.r1_we; r1_addr = v.r1_addr; r1_wdata = v.r1_wdata;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      r0_funct3 = 3'b010;
      r1_funct3 = 3'b100;
      // Loads from reset under contention: core first, then loader.
      tv[0]  = mk(1,0,32'h1000,0, 1,0,32'h2000,0, 1,0,0,0,0, 32'h1000,0,0);
      tv[1]  = mk(0,0,32'h1000,0, 1,0,32'h2000,0, 0,0,1,0,0, 32'h1000,0,memf(32'h1000));
      tv[2]  = mk(0,0,32'h1000,0, 1,0,32'h2000,0, 0,1,0,0,0, 32'h2000,0,0);
      tv[3]  = mk(0,0,32'h1000,0, 0,0,32'h2000,0, 0,0,0,1,0, 32'h1000,0,memf(32'h2000));
      // Lone core load.
      tv[4]  = mk(1,0,32'h1000,0, 0,0,0,0, 1,0,0,0,0, 32'h1000,0,0);
      tv[5]  = mk(0,0,32'h1000,0, 0,0,0,0, 0,0,1,0,0, 32'h1000,0,memf(32'h1000));
      // Back-to-back loader stores.
      tv[6]  = mk(0,0,0,0, 1,1,32'h10,32'hA5A5A5A5, 0,1,0,0,1, 32'h10,32'hA5A5A5A5,0);
      tv[7]  = mk(0,0,0,0, 1,1,32'h14,32'hA5A5A5A5, 0,1,0,0,1, 32'h14,32'hA5A5A5A5,0);
      tv[8]  = mk(0,0,0,0, 1,1,32'h18,32'hA5A5A5A5, 0,1,0,0,1, 32'h18,32'hA5A5A5A5,0);
      // Continuous contending stores alternate.
      tv[9]  = mk(1,1,32'h100,32'h11111111, 1,1,32'h200,32'h22222222,
                  1,0,0,0,1, 32'h100,32'h11111111,0);
      tv[10] = mk(1,1,32'h100,32'h11111111, 1,1,32'h200,32'h22222222,
                  0,1,0,0,1, 32'h200,32'h22222222,0);
      tv[11] = mk(1,1,32'h100,32'h11111111, 1,1,32'h200,32'h22222222,
                  1,0,0,0,1, 32'h100,32'h11111111,0);
      tv[12] = mk(1,1,32'h100,32'h11111111, 1,1,32'h200,32'h22222222,
                  0,1,0,0,1, 32'h200,32'h22222222,0);
      // Sole loader request wins even though it was granted last.
      tv[13] = mk(0,0,0,0, 1,0,32'h300,0, 0,1,0,0,0, 32'h300,0,0);
      tv[14] = mk(0,0,0,0, 0,0,32'h300,0, 0,0,0,1,0, 32'h0,0,memf(32'h300));
      // Loader store request withdrawn during the core's RDATA cycle.
      tv[15] = mk(1,0,32'h40,0, 1,1,32'h80,32'hDEADBEEF, 1,0,0,0,0, 32'h40,0,0);
      tv[16] = mk(0,0,32'h40,0, 1,1,32'h80,32'hDEADBEEF, 0,0,1,0,0, 32'h40,0,memf(32'h40));
      tv[17] = mk(0,0,32'h40,0, 0,1,32'h80,32'hDEADBEEF, 0,0,0,0,0, 32'h40,0,0);

      // Reset with both ports requesting: outputs must stay quiet.
      rst_n = 1'b0;
      drive(tv[0]);
      #2;
      chk("rst_r0_gnt", -1, 32'(r0_gnt), 0);
      chk("rst_r1_gnt", -1, 32'(r1_gnt), 0);
      chk("rst_wren", -1, 32'(mem_wren), 0);
      chk("rst_rvalid", -1, {30'd0, r1_rvalid, r0_rvalid}, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(tv[i]);
         @(negedge clk);
         chk("r0_gnt", i, 32'(r0_gnt), 32'(tv[i].e_g0));
         chk("r1_gnt", i, 32'(r1_gnt), 32'(tv[i].e_g1));
         chk("r0_rvalid", i, 32'(r0_rvalid), 32'(tv[i].e_rv0));
         chk("r1_rvalid", i, 32'(r1_rvalid), 32'(tv[i].e_rv1));
         chk("mem_wren", i, 32'(mem_wren), 32'(tv[i].e_wren));
         chk("mem_addr", i, mem_addr, tv[i].e_addr);
         chk("mem_funct3", i, 32'(mem_funct3), tv[i].e_g1 ? 32'd4 : 32'd2);
         if (tv[i].e_wren) chk("mem_wdata", i, mem_wdata, tv[i].e_wdata);
         if (tv[i].e_rv0) chk("r0_rdata", i, r0_rdata, tv[i].e_rdata);
         if (tv[i].e_rv1) chk("r1_rdata", i, r1_rdata, tv[i].e_rdata);
         @(posedge clk);
         #1;
      end

      // Reset while the loader's load is outstanding.
      r0_req = 1'b0; r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h500;
      @(negedge clk);
      chk("seq_r1_gnt", 100, 32'(r1_gnt), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h600;
      #1;
      chk("seq_rst_r1_rvalid", 101, 32'(r1_rvalid), 0);
      chk("seq_rst_gnt", 101, {30'd0, r1_gnt, r0_gnt}, 0);
      chk("seq_rst_wren", 101, 32'(mem_wren), 0);
      @(negedge clk);
      chk("seq_rst_r1_rvalid2", 102, 32'(r1_rvalid), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("seq_post_r0_gnt", 103, 32'(r0_gnt), 1);
      chk("seq_post_r1_gnt", 103, 32'(r1_gnt), 0);
      chk("seq_post_r1_rvalid", 103, 32'(r1_rvalid), 0);
      chk("seq_post_addr", 103, mem_addr, 32'h600);
      @(posedge clk);
      #1 r0_req = 1'b0; r1_req = 1'b0;
      #1;
      chk("seq_post_r0_rvalid", 104, 32'(r0_rvalid), 1);
      chk("seq_post_r1_rvalid2", 104, 32'(r1_rvalid), 0);
      chk("seq_post_rdata", 104, r0_rdata, memf(32'h600));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
